// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: binary to BCD via iterative double-dabble,
// then a round-robin 4-digit scan with optional leading-zero blanking.
module seven_segment_scanner #(
  parameter int BIN_W       = 16,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  in_value,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              blank_lz,
  output logic              busy,
  output logic              ovf,
  output logic [3:0]        digit,
  output logic [DIGITS-1:0] anode_n
);

  localparam int SR_W = 16 + BIN_W;
  localparam int CW   = $clog2(BIN_W + 1);
  localparam int PW   = $clog2(REFRESH_DIV);
  localparam int XW   = (BIN_W > 14) ? BIN_W : 14;

  generate
    if (DIGITS != 4) begin : g_bad_digits
      $error("seven_segment_scanner: DIGITS must be 4");
    end
    if (REFRESH_DIV < 2) begin : g_bad_div
      $error("seven_segment_scanner: REFRESH_DIV must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [CW-1:0]     cnt;
  logic [15:0]       disp;
  logic [XW-1:0]     in_ext;
  logic              sat;
  logic [BIN_W-1:0]  operand;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Values above four decimal digits are clamped to 9999.
  assign in_ext  = XW'(in_value);
  assign sat     = in_ext > XW'(9999);
  assign operand = sat ? BIN_W'(9999) : in_value;

  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < 4; k++) begin
      if (sr[BIN_W+4*k +: 4] >= 4'd5) begin
        sr_adj[BIN_W+4*k +: 4] = sr[BIN_W+4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      disp  <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= {16'd0, operand};
            cnt   <= '0;
            ovf   <= sat;
            state <= CONV;
          end
        end
        CONV: begin
          sr  <= {sr_adj[SR_W-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(BIN_W - 1)) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          disp  <= sr[SR_W-1 -: 16];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [1:0]    idx_n;
  logic          wrap;
  logic [3:0]    nib_n;
  logic          hi_zero;
  logic          blank_n;
  logic [3:0]    onehot_n;

  assign wrap  = (pre == PW'(REFRESH_DIV - 1));
  assign idx_n = wrap ? idx + 2'd1 : idx;

  // Outputs follow the index the slot will hold after this edge.
  always_comb begin
    nib_n    = disp[3:0];
    hi_zero  = 1'b0;
    onehot_n = 4'b1110;
    unique case (idx_n)
      2'd0: begin
        nib_n    = disp[3:0];
        hi_zero  = 1'b0;
        onehot_n = 4'b1110;
      end
      2'd1: begin
        nib_n    = disp[7:4];
        hi_zero  = (disp[15:4] == 12'd0);
        onehot_n = 4'b1101;
      end
      2'd2: begin
        nib_n    = disp[11:8];
        hi_zero  = (disp[15:8] == 8'd0);
        onehot_n = 4'b1011;
      end
      2'd3: begin
        nib_n    = disp[15:12];
        hi_zero  = (disp[15:12] == 4'd0);
        onehot_n = 4'b0111;
      end
      default: begin
        nib_n    = disp[3:0];
        hi_zero  = 1'b0;
        onehot_n = 4'b1110;
      end
    endcase
  end

  assign blank_n = blank_lz & hi_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= '0;
      idx     <= 2'd0;
      digit   <= 4'd0;
      anode_n <= DIGITS'(4'b1110);
    end else begin
      pre     <= wrap ? '0 : pre + PW'(1);
      idx     <= idx_n;
      digit   <= nib_n;
      anode_n <= DIGITS'(blank_n ? 4'b1111 : onehot_n);
    end
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Drives a multi-digit, time-multiplexed seven-segment display from a binary count, such as the muon-lifetime event count or the decay time in bins. Accepts a binary value over a valid/ready handshake and converts it to BCD with an iterative double-dabble engine. Scans the digits round-robin, presenting one 4-bit digit code per slot to the downstream `seven_segment_decoder` and driving the matching active-low anode.

## Interface
- `BIN_W`, 16, width of the binary input value.
- `DIGITS`, 4, number of display digits. The implementation supports 4 only; any other value is a compile-time error.
- `REFRESH_DIV`, 50000, clock cycles each digit slot is held. Minimum 2.
- `clk` input 1 — system clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `in_value` input BIN_W — binary value to display.
- `in_valid` input 1 — `in_value` is offered.
- `in_ready` output 1 — block can accept a value.
- `blank_lz` input 1 — when 1, leading zeros are blanked.
- `busy` output 1 — conversion in progress.
- `ovf` output 1 — the last accepted value exceeded 9999.
- `digit` output 4 — BCD code for the active slot. Connects to `seven_segment_decoder.digit`.
- `anode_n` output DIGITS — one-hot active-low digit enable. Bit 0 is the least-significant digit.

## Operation
- Control FSM has three states.
  - IDLE: `in_ready`=1, `busy`=0. If `in_valid` is 1, the block captures the value and goes to CONV.
  - CONV: `in_ready`=0, `busy`=1. Runs exactly BIN_W iterations, then goes to LOAD.
  - LOAD: copies the 4 BCD nibbles into the display register, then returns to IDLE.
- Saturation at capture:
  - If `in_value` > 9999, the captured operand is 9999 and `ovf` is set to 1.
  - Otherwise the captured operand is `in_value` and `ovf` is cleared to 0.
  - `ovf` updates on the same capture edge.
- Double-dabble iteration: shift register = {16-bit BCD, BIN_W-bit binary}. Each cycle, first add 3 to every BCD nibble that is ≥5, then shift the whole register left by 1.
- The display register holds the previous value throughout CONV. It changes only in LOAD.
- `in_valid` is ignored while `in_ready`=0. No queuing: values offered while busy are dropped by design, and the producer must hold or retry.
- Scanner, independent of the FSM:
  - A prescaler counts 0..REFRESH_DIV-1.
  - On wrap, the slot index advances 0→1→2→3→0.
  - `digit` = display nibble[index]. `anode_n` = ~(1<<index).
- Leading-zero blanking, when `blank_lz`=1:
  - Slot k>0 is blanked if nibble k and all higher nibbles are 0.
  - A blanked slot drives `anode_n` all ones; `digit` still carries the nibble.
  - Slot 0 is never blanked.
  - `blank_lz` is sampled combinationally into the registered outputs on every cycle.

## Timing
- Reset values:
  - FSM = IDLE, `in_ready`=1, `busy`=0, `ovf`=0.
  - Display register = 0, prescaler = 0, index = 0.
  - `digit`=0, `anode_n`=4'b1110.
- All outputs are registered except `in_ready` and `busy`, which decode directly from the FSM state.
- Latency:
  - Handshake accepted at edge N.
  - CONV occupies edges N+1..N+BIN_W.
  - LOAD at edge N+BIN_W+1: the display register is updated and `in_ready` returns to 1 after this edge.
  - Total: BIN_W+1 cycles from acceptance to new display data.
  - The new value appears on `digit` at the first clock after LOAD; slot index is unaffected.
- Back-to-back throughput: one value per BIN_W+2 cycles.
- Slot change: `digit`/`anode_n` update on the edge where the prescaler wraps from REFRESH_DIV-1 to 0. Each slot is held exactly REFRESH_DIV cycles.
- Simultaneous events:
  - LOAD coinciding with a prescaler wrap: the new index shows the new data on the next edge; no glitch cycle with mixed old/new data.
  - `in_valid` asserting in the same cycle as LOAD is not accepted, because `in_ready` is 0 in that cycle.
- Reset mid-conversion:
  - The conversion is aborted and all state returns to reset values.
  - The display shows 0 and `ovf`=0.
  - The aborted value is discarded.

## Test plan
- Reset: assert `rst_n`=0 mid-scan → `anode_n`=1110, `digit`=0, `in_ready`=1, `busy`=0, `ovf`=0. Use REFRESH_DIV=4 in the bench.
- Conversion of 1234:
  - Stimulus: handshake `in_value`=1234.
  - Required: `busy` high for 17 cycles (16 CONV + LOAD).
  - Required: nibbles 4,3,2,1 appear on `digit` in slot order 0..3 with `anode_n` 1110, 1101, 1011, 0111, each slot held 4 cycles.
- Overflow: `in_value`=12345 → `ovf`=1, display 9,9,9,9. Then `in_value`=42 → `ovf`=0.
- Blanking: `in_value`=7 with `blank_lz`=1 → slot 0 shows `anode_n`=1110, `digit`=7; slots 1–3 show `anode_n`=1111. With `blank_lz`=0, all slots are enabled and slots 1–3 show `digit`=0.
- Busy drop: with 1234 in conversion, pulse `in_valid` with 5678 → it is not accepted and the display ends at 1234. Values 0, 9999 and 65535 all convert correctly (65535 → 9999 with `ovf`=1).
- Reset mid-conversion:
  - Stimulus: pull `rst_n` low 5 cycles after accepting 4321.
  - Required: display 0 and FSM IDLE.
  - Required: after release, the next handshake with 8 converts normally in 17 cycles.
